instr_fetch_unit: RTL and testbench
===================================

# instr_fetch_unit

Reads the byte-wide program memory that the loader fills through `pmWrEn`/`pmAddr`/`instructionIn`. It assembles each group of four consecutive little-endian bytes into a 32-bit RV32-style instruction and hands it to the decode stage over a valid/ready handshake. It owns the program counter and stops fetching when it assembles a HALT word.

## Interface
- `ADDR_WIDTH`, default 7: program memory byte-address width.
- `INSTR_WIDTH`, default 8: width of one program memory byte lane.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `pmWrEn` in 1: loader is writing program memory. While high, fetch is suspended and the block is forced to IDLE.
- `pmRdEn` out 1: read strobe to program memory.
- `pmRdAddr` out ADDR_WIDTH: byte address being read.
- `pmRdData` in INSTR_WIDTH: read data, valid exactly one cycle after the `pmRdEn` cycle.
- `instrOut` out 32: assembled instruction (byte at PC in [7:0], byte at PC+3 in [31:24]).
- `instrValid` out 1: `instrOut` holds a valid instruction.
- `instrReady` in 1: decode accepts `instrOut`.
- `pcOut` out ADDR_WIDTH: byte address of the word in `instrOut`, or of the word being fetched.
- `halted` out 1: HALT word reached; fetch stopped.

## Operation
- States: IDLE, FETCH, DRAIN, VALID, HALT.
- IDLE:
  - Entered on reset or whenever `pmWrEn`=1, from any state. Entry clears PC to 0, `halted`, byte counter and assembly register.
  - Moves to FETCH on the first edge where `pmWrEn`=0.
- FETCH: 4 cycles.
  - Cycle k (k=0..3) drives `pmRdEn`=1, `pmRdAddr`=PC+k (mod 2^ADDR_WIDTH).
  - Byte returned for read k is written into assembly bits [8k+7:8k] on the following edge.
- DRAIN: 1 cycle. `pmRdEn`=0; captures byte 3; then goes to VALID.
- VALID:
  - If assembled word [6:0]==7'b0000001 (HALT): `instrValid` stays 0, `halted`=1, go to HALT.
  - Otherwise `instrValid`=1 and `instrOut` is held stable until `instrValid && instrReady`.
  - On that edge: PC += 4 (mod 2^ADDR_WIDTH), go to FETCH.
- HALT: no reads, `instrValid`=0, `halted`=1. Leaves only via `rst` or `pmWrEn`.
- All-zero word (NOP): issued like any instruction, unless the macro below is defined.
- PC wraps from 124 to 0. Byte addresses inside a word wrap mod 128.
- `pmWrEn` rising mid-FETCH/DRAIN/VALID:
  - Partial word is discarded; `instrValid` drops on the next edge.
  - No handshake completes on that edge even if `instrReady`=1.

## Timing
- Reset values: `pmRdEn`=0, `pmRdAddr`=0, `instrOut`=0, `instrValid`=0, `pcOut`=0, `halted`=0, state IDLE.
- All outputs are registered.
- Fetch latency:
  - FETCH entered on edge E; reads at E..E+3.
  - `instrValid` rises at E+5 (4 FETCH cycles + 1 DRAIN + VALID registration).
  - Steady state is 6 cycles per instruction with `instrReady` held at 1.
- Handshake:
  - Transfer occurs on an edge where `instrValid`=1 and `instrReady`=1.
  - `instrValid` falls on that edge; `instrOut` and `pcOut` update only on transfer or IDLE entry.
  - `instrReady` may be high before `instrValid`; there is no combinational ready-to-valid path.
- `halted` rises on the edge that would otherwise raise `instrValid`.
- `pmWrEn` has priority over every transition, including simultaneous handshake or HALT detection.

## Configuration
- `FETCH_SKIP_NOP_EN` defined: an assembled 32'h0000_0000 is never presented. In VALID it does PC += 4 and goes directly to FETCH, with `instrValid` kept 0. This costs 1 cycle and the NOP is invisible to decode.
- Not defined: all-zero words are presented and handshaked as normal instructions.

## Test plan
- Load 0x00300093 at addr 0 and HALT at 4, release `pmWrEn`, hold `instrReady`=1:
  - reads addr 0,1,2,3;
  - `instrOut`=32'h00300093, `pcOut`=0, `instrValid` 5 cycles after FETCH entry;
  - then `halted`=1 and `instrValid` never rises for addr 4.
- Back-pressure: three ADD words, `instrReady`=0 for 10 cycles after first valid:
  - `instrOut`/`pcOut` stable, no reads issued;
  - on release, `pcOut` sequence is 0, 4, 8.
- NOP at addr 8 between two instructions:
  - without macro, 32'h0 presented at `pcOut`=8;
  - with `FETCH_SKIP_NOP_EN`, next presented `pcOut` is 12.
- Wrap: preload addr 124–127 with ADD and 0–3 with HALT, force start by reloading only those words:
  - after PC=124 transfer, next reads are addr 0..3;
  - then `halted`=1.
- Assert `pmWrEn` during the FETCH cycle reading addr 2:
  - next cycle IDLE, `pmRdEn`=0, `instrValid`=0, `pcOut`=0;
  - after release, refetch starts at addr 0.
- Assert `rst` asynchronously while in VALID: all outputs reach reset values without a clock edge.

Source files
------------

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : instr_fetch_unit
// Description : Fetches four little-endian bytes from the byte-wide program
//               memory, assembles a 32-bit instruction and offers it to
//               decode over a valid/ready handshake. Owns the PC and stops
//               at a HALT word (opcode field 7'b0000001).
//               Optional macro FETCH_SKIP_NOP_EN: an all-zero word is
//               silently skipped instead of being presented.
// Revision    : 1.0 - initial release
// ============================================================================
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 7,
  parameter int INSTR_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   pmWrEn,
  output logic                   pmRdEn,
  output logic [ADDR_WIDTH-1:0]  pmRdAddr,
  input  logic [INSTR_WIDTH-1:0] pmRdData,
  output logic [31:0]            instrOut,
  output logic                   instrValid,
  input  logic                   instrReady,
  output logic [ADDR_WIDTH-1:0]  pcOut,
  output logic                   halted
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_DRAIN = 3'd2,
    S_VALID = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  localparam logic [6:0] HALT_OPCODE = 7'b0000001;

  state_t                  state, state_n;
  logic [1:0]              byte_cnt, byte_cnt_n;
  logic [ADDR_WIDTH-1:0]   pc, pc_n;
  logic [23:0]             asm_word, asm_word_n;
  logic                    rd_en, rd_en_n;
  logic [ADDR_WIDTH-1:0]   rd_addr, rd_addr_n;
  logic [31:0]             instr_out, instr_out_n;
  logic                    instr_valid, instr_valid_n;
  logic                    halted_q, halted_n;
  logic [31:0]             full_word;
  logic [7:0]              rd_byte;

  // Byte 3 arrives during DRAIN and is merged combinationally with bytes 0..2.
  assign rd_byte   = pmRdData[7:0];
  assign full_word = {rd_byte, asm_word};

  // Next-state and next-output logic; loader activity overrides everything.
  always_comb begin
    state_n       = state;
    byte_cnt_n    = byte_cnt;
    pc_n          = pc;
    asm_word_n    = asm_word;
    rd_en_n       = rd_en;
    rd_addr_n     = rd_addr;
    instr_out_n   = instr_out;
    instr_valid_n = instr_valid;
    halted_n      = halted_q;

    if (pmWrEn) begin
      state_n       = S_IDLE;
      byte_cnt_n    = 2'd0;
      pc_n          = '0;
      asm_word_n    = '0;
      rd_en_n       = 1'b0;
      rd_addr_n     = '0;
      instr_out_n   = '0;
      instr_valid_n = 1'b0;
      halted_n      = 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          state_n    = S_FETCH;
          byte_cnt_n = 2'd0;
          rd_en_n    = 1'b1;
          rd_addr_n  = pc;
        end

        S_FETCH: begin
          // Data for the read issued last cycle is on pmRdData now.
          case (byte_cnt)
            2'd1:    asm_word_n[7:0]   = rd_byte;
            2'd2:    asm_word_n[15:8]  = rd_byte;
            2'd3:    asm_word_n[23:16] = rd_byte;
            default: ;
          endcase
          if (byte_cnt == 2'd3) begin
            state_n = S_DRAIN;
            rd_en_n = 1'b0;
          end else begin
            byte_cnt_n = byte_cnt + 2'd1;
            rd_addr_n  = rd_addr + ADDR_WIDTH'(1);
          end
        end

        S_DRAIN: begin
          if (full_word[6:0] == HALT_OPCODE) begin
            state_n  = S_HALT;
            halted_n = 1'b1;
          end else begin
            state_n       = S_VALID;
            instr_out_n   = full_word;
            instr_valid_n = 1'b1;
`ifdef FETCH_SKIP_NOP_EN
            // A NOP parks in VALID for one cycle without being offered.
            if (full_word == 32'h0000_0000) begin
              instr_out_n   = instr_out;
              instr_valid_n = 1'b0;
            end
`endif
          end
        end

        S_VALID: begin
          if ((instr_valid && instrReady) || !instr_valid) begin
            // Transfer (or skipped NOP): advance PC and start the next fetch.
            instr_valid_n = 1'b0;
            pc_n          = pc + ADDR_WIDTH'(4);
            state_n       = S_FETCH;
            byte_cnt_n    = 2'd0;
            rd_en_n       = 1'b1;
            rd_addr_n     = pc + ADDR_WIDTH'(4);
          end
        end

        S_HALT: begin
          rd_en_n       = 1'b0;
          instr_valid_n = 1'b0;
          halted_n      = 1'b1;
        end

        default: begin
          state_n = S_IDLE;
        end
      endcase
    end
  end

  // State and registered outputs with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= S_IDLE;
      byte_cnt    <= 2'd0;
      pc          <= '0;
      asm_word    <= '0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      instr_out   <= '0;
      instr_valid <= 1'b0;
      halted_q    <= 1'b0;
    end else begin
      state       <= state_n;
      byte_cnt    <= byte_cnt_n;
      pc          <= pc_n;
      asm_word    <= asm_word_n;
      rd_en       <= rd_en_n;
      rd_addr     <= rd_addr_n;
      instr_out   <= instr_out_n;
      instr_valid <= instr_valid_n;
      halted_q    <= halted_n;
    end
  end

  assign pmRdEn     = rd_en;
  assign pmRdAddr   = rd_addr;
  assign instrOut   = instr_out;
  assign instrValid = instr_valid;
  assign pcOut      = pc;
  assign halted     = halted_q;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_instr_fetch_unit
// Description : Self-checking bench for instr_fetch_unit. A timeline model
//               (cycles since fetch start, words read straight from memory)
//               is compared against the DUT every cycle, alongside directed
//               literal checks and randomized traffic.
//               Honours FETCH_SKIP_NOP_EN when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pmWrEn = 1'b1;
  logic        pmRdEn;
  logic [6:0]  pmRdAddr;
  logic [7:0]  pmRdData = 8'h00;
  logic [31:0] instrOut;
  logic        instrValid;
  logic        instrReady = 1'b0;
  logic [6:0]  pcOut;
  logic        halted;

  instr_fetch_unit #(.ADDR_WIDTH(7), .INSTR_WIDTH(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .pmWrEn     (pmWrEn),
    .pmRdEn     (pmRdEn),
    .pmRdAddr   (pmRdAddr),
    .pmRdData   (pmRdData),
    .instrOut   (instrOut),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .pcOut      (pcOut),
    .halted     (halted)
  );

  always #5 clk = ~clk;

  // Program memory: read data valid one cycle after the strobe.
  logic [7:0] mem [0:127];
  always @(posedge clk) if (pmRdEn) pmRdData <= mem[pmRdAddr];

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] word_at(input logic [6:0] a);
    logic [6:0] a1, a2, a3;
    a1 = a + 7'd1;
    a2 = a + 7'd2;
    a3 = a + 7'd3;
    return {mem[a3], mem[a2], mem[a1], mem[a]};
  endfunction

  task automatic put_word(input logic [6:0] a, input logic [31:0] w);
    logic [6:0] a1, a2, a3;
    a1 = a + 7'd1;
    a2 = a + 7'd2;
    a3 = a + 7'd3;
    mem[a] = w[7:0]; mem[a1] = w[15:8]; mem[a2] = w[23:16]; mem[a3] = w[31:24];
  endtask

  // ---------------- timeline reference model ----------------
  // phase = cycles since fetch began (-1 when idle); word appears at phase 5.
  logic [6:0]  m_pc     = 7'd0;
  int          m_phase  = -1;
  logic        m_valid  = 1'b0;
  logic        m_halted = 1'b0;
  logic        m_skip   = 1'b0;
  logic [31:0] m_word   = 32'h0;
  logic [31:0] w_tmp;

  always @(posedge clk or posedge rst) begin
    if (rst || pmWrEn) begin
      m_pc = 7'd0; m_phase = -1; m_valid = 1'b0; m_halted = 1'b0; m_skip = 1'b0; m_word = 32'h0;
    end else if (m_halted) begin
      m_halted = 1'b1;
    end else if (m_phase == -1) begin
      m_phase = 0;
    end else if (m_skip) begin
      m_skip = 1'b0; m_pc = m_pc + 7'd4; m_phase = 0;
    end else if (m_valid) begin
      if (instrReady) begin
        m_valid = 1'b0; m_pc = m_pc + 7'd4; m_phase = 0;
      end
    end else begin
      m_phase = m_phase + 1;
      if (m_phase == 5) begin
        w_tmp = word_at(m_pc);
        if (w_tmp[6:0] == 7'b0000001) m_halted = 1'b1;
`ifdef FETCH_SKIP_NOP_EN
        else if (w_tmp == 32'h0) m_skip = 1'b1;
`endif
        else begin m_valid = 1'b1; m_word = w_tmp; end
      end
    end
  end

  // Every-cycle comparison against the model.
  logic exp_rd;
  always @(negedge clk) begin
    if (!rst) begin
      exp_rd = (m_phase >= 0) && (m_phase <= 3) && !m_valid && !m_halted && !m_skip;
      check("model_pmRdEn", {31'd0, pmRdEn}, {31'd0, exp_rd});
      if (exp_rd) check("model_pmRdAddr", {25'd0, pmRdAddr}, {25'd0, m_pc + 7'(m_phase)});
      check("model_instrValid", {31'd0, instrValid}, {31'd0, m_valid});
      if (m_valid) check("model_instrOut", instrOut, m_word);
      check("model_pcOut", {25'd0, pcOut}, {25'd0, m_pc});
      check("model_halted", {31'd0, halted}, {31'd0, m_halted});
    end
  end

  // Record completed transfers.
  logic [6:0]  xfer_pc[$];
  logic [31:0] xfer_word[$];
  always @(posedge clk) begin
    if (!rst && !pmWrEn && instrValid && instrReady) begin
      xfer_pc.push_back(pcOut);
      xfer_word.push_back(instrOut);
    end
  end

  task automatic wait_halted(input int budget);
    int n;
    n = 0;
    while (!halted && n < budget) begin @(negedge clk); n++; end
    check("halt_reached", {31'd0, halted}, 32'd1);
  endtask

  task automatic wait_valid(input int budget);
    int n;
    n = 0;
    while (!instrValid && n < budget) begin @(negedge clk); n++; end
    check("valid_reached", {31'd0, instrValid}, 32'd1);
  endtask

  task automatic begin_load();
    pmWrEn = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    xfer_pc.delete();
    xfer_word.delete();
  endtask

  localparam logic [31:0] ADD0 = 32'h002081B3;
  localparam logic [31:0] ADD1 = 32'h00308133;
  localparam logic [31:0] ADD2 = 32'h004101B3;
  localparam logic [31:0] HALTW = 32'h00000001;

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;

    // Reset state.
    repeat (2) @(negedge clk);
    check("rst_pmRdEn", {31'd0, pmRdEn}, 32'd0);
    check("rst_pmRdAddr", {25'd0, pmRdAddr}, 32'd0);
    check("rst_instrOut", instrOut, 32'd0);
    check("rst_instrValid", {31'd0, instrValid}, 32'd0);
    check("rst_pcOut", {25'd0, pcOut}, 32'd0);
    check("rst_halted", {31'd0, halted}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Basic fetch then HALT, with exact latency.
    begin_load();
    put_word(7'd0, 32'h00300093);
    put_word(7'd4, HALTW);
    instrReady = 1'b1;
    pmWrEn = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check("t1_rd_en", {31'd0, pmRdEn}, 32'd1);
      check("t1_rd_addr", {25'd0, pmRdAddr}, k);
    end
    @(negedge clk);
    check("t1_drain_rd", {31'd0, pmRdEn}, 32'd0);
    check("t1_drain_valid", {31'd0, instrValid}, 32'd0);
    @(negedge clk);
    check("t1_valid", {31'd0, instrValid}, 32'd1);
    check("t1_instr", instrOut, 32'h00300093);
    check("t1_pc", {25'd0, pcOut}, 32'd0);
    wait_halted(30);
    repeat (3) @(negedge clk);
    check("t1_no_valid_after_halt", {31'd0, instrValid}, 32'd0);
    check("t1_xfer_count", xfer_pc.size(), 32'd1);

    // Back-pressure.
    begin_load();
    put_word(7'd0, ADD0); put_word(7'd4, ADD1); put_word(7'd8, ADD2); put_word(7'd12, HALTW);
    instrReady = 1'b0;
    pmWrEn = 1'b0;
    wait_valid(20);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("bp_instr_stable", instrOut, ADD0);
      check("bp_pc_stable", {25'd0, pcOut}, 32'd0);
      check("bp_no_read", {31'd0, pmRdEn}, 32'd0);
    end
    instrReady = 1'b1;
    wait_halted(60);
    check("bp_xfer_count", xfer_pc.size(), 32'd3);
    if (xfer_pc.size() == 3) begin
      check("bp_pc0", {25'd0, xfer_pc[0]}, 32'd0);
      check("bp_pc1", {25'd0, xfer_pc[1]}, 32'd4);
      check("bp_pc2", {25'd0, xfer_pc[2]}, 32'd8);
      check("bp_word2", xfer_word[2], ADD2);
    end

    // NOP between instructions.
    begin_load();
    put_word(7'd0, ADD0); put_word(7'd4, ADD1); put_word(7'd8, 32'h0);
    put_word(7'd12, ADD2); put_word(7'd16, HALTW);
    instrReady = 1'b1;
    pmWrEn = 1'b0;
    wait_halted(80);
`ifdef FETCH_SKIP_NOP_EN
    check("nop_xfer_count", xfer_pc.size(), 32'd3);
    if (xfer_pc.size() == 3) check("nop_skipped_pc", {25'd0, xfer_pc[2]}, 32'd12);
`else
    check("nop_xfer_count", xfer_pc.size(), 32'd4);
    if (xfer_pc.size() == 4) begin
      check("nop_pc", {25'd0, xfer_pc[2]}, 32'd8);
      check("nop_word", xfer_word[2], 32'h0);
    end
`endif

    // PC wrap from 124 back to 0.
    begin_load();
    for (int i = 0; i < 32; i++) put_word(7'(i * 4), ADD1);
    instrReady = 1'b1;
    pmWrEn = 1'b0;
    begin
      int n;
      n = 0;
      while (xfer_pc.size() < 17 && n < 200) begin @(negedge clk); n++; end
      check("wrap_progress", {31'd0, (xfer_pc.size() >= 17)}, 32'd1);
    end
    put_word(7'd0, HALTW);
    wait_halted(200);
    check("wrap_xfer_count", xfer_pc.size(), 32'd32);
    if (xfer_pc.size() == 32) check("wrap_last_pc", {25'd0, xfer_pc[31]}, 32'd124);

    // Loader interrupts fetch mid-word.
    begin_load();
    put_word(7'd0, ADD0); put_word(7'd4, HALTW);
    pmWrEn = 1'b0;
    begin
      int n;
      n = 0;
      while (!(pmRdEn && pmRdAddr == 7'd2) && n < 10) begin @(negedge clk); n++; end
      check("abort_reach_addr2", {31'd0, (pmRdEn && pmRdAddr == 7'd2)}, 32'd1);
    end
    pmWrEn = 1'b1;
    @(negedge clk);
    check("abort_rd", {31'd0, pmRdEn}, 32'd0);
    check("abort_valid", {31'd0, instrValid}, 32'd0);
    check("abort_pc", {25'd0, pcOut}, 32'd0);
    pmWrEn = 1'b0;
    @(negedge clk);
    check("abort_refetch_en", {31'd0, pmRdEn}, 32'd1);
    check("abort_refetch_addr", {25'd0, pmRdAddr}, 32'd0);
    wait_halted(40);

    // Asynchronous reset while VALID.
    begin_load();
    put_word(7'd0, ADD2); put_word(7'd4, HALTW);
    instrReady = 1'b0;
    pmWrEn = 1'b0;
    wait_valid(20);
    #2 rst = 1'b1;
    #1;
    check("arst_valid", {31'd0, instrValid}, 32'd0);
    check("arst_instr", instrOut, 32'd0);
    check("arst_pc", {25'd0, pcOut}, 32'd0);
    check("arst_rd", {31'd0, pmRdEn}, 32'd0);
    check("arst_addr", {25'd0, pmRdAddr}, 32'd0);
    check("arst_halted", {31'd0, halted}, 32'd0);
    pmWrEn = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Randomized traffic.
    for (int r = 0; r < 4; r++) begin
      begin_load();
      for (int i = 0; i < 32; i++) begin
        int sel;
        logic [31:0] w;
        sel = $urandom_range(0, 11);
        w = $urandom;
        if (sel == 0) w = HALTW;
        else if (sel == 1) w = 32'h0;
        else w[6:0] = 7'h33;
        put_word(7'(i * 4), w);
      end
      pmWrEn = 1'b0;
      for (int c = 0; c < 400; c++) begin
        @(negedge clk);
        instrReady = $urandom_range(0, 1) == 1;
        if (pmWrEn) pmWrEn = 1'b0;
        else if (halted || $urandom_range(0, 99) == 0) begin
          pmWrEn = 1'b1;
          put_word(7'($urandom_range(0, 31) * 4), {$urandom, 7'h13} >> 7);
        end
      end
    end

    pmWrEn = 1'b1;
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
